seq_nibble_compare: RTL and testbench

- Sequential front-end that feeds our 4-bit cascadable magnitude-compare slice.
- Accepts two WIDTH-bit operands over a valid/ready handshake.
- Walks the operands MSB nibble first, one nibble per cycle, through the slice, carrying the lt/eq/gt cascade in registers.
- Returns a single registered lt/eq/gt verdict over a valid/ready handshake, for wide compares in datapaths that cannot afford a flat WIDTH-bit comparator.

---
 rtl/cmp_pkg.sv | 25 ++
 rtl/cmp4_slice.sv | 28 ++
 rtl/seq_nibble_compare.sv | 154 +++++++++++++++
 tb/tb_seq_nibble_compare.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types and helpers for the sequential nibble comparator.
//
// Contents:
//   cmp_res_t  - 2-bit magnitude verdict carried along the slice cascade
//   state_t    - controller states of seq_nibble_compare
//   nib_count  - number of 4-bit nibbles in a WIDTH-bit operand
package cmp_pkg;

  typedef enum logic [1:0] {
    CMP_EQ = 2'd0,
    CMP_LT = 2'd1,
    CMP_GT = 2'd2
  } cmp_res_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nib_count(input int width);
    return width / 4;
  endfunction

endpackage

// File: rtl/cmp4_slice.sv
// Combinational 4-bit cascadable magnitude-compare slice.
//
// Ports:
//   a, b  in   4-bit nibbles to compare
//   cin   in   incoming cascade verdict
//   res   out  slice verdict
//
// A nibble pair that differs decides the verdict on its own; an equal pair
// passes the incoming cascade through unchanged.
module cmp4_slice
  import cmp_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  cmp_res_t   cin,
  output cmp_res_t   res
);

  always_comb begin
    res = cin;
    if (a < b) begin
      res = CMP_LT;
    end else if (a > b) begin
      res = CMP_GT;
    end
  end

endmodule

// File: rtl/seq_nibble_compare.sv
// Sequential wide magnitude comparator built around one 4-bit slice.
//
// An operand pair is accepted in IDLE, then walked MSB nibble first through
// cmp4_slice, one nibble per clock, with the cascade verdict held in a
// register. The final verdict is presented in DONE until the consumer takes it.
//
// Parameters:
//   WIDTH       operand width, multiple of 4 and >= 4
//   EARLY_EXIT  1: stop at the first unequal nibble, 0: always scan all nibbles
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   operand pair present
//   in_ready   out  operand pair can be accepted (IDLE)
//   in_a/in_b  in   operands
//   out_valid  out  verdict present (DONE)
//   out_ready  in   consumer takes the verdict
//   out_lt/out_eq/out_gt  out  one-hot verdict, all zero outside DONE
//   busy       out  high in SCAN or DONE
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; a producer holds its data stable while valid is high and ready
// is low.
//
// Optional build macro SEQ_NIBBLE_COMPARE_SIGNED_CMP_EN: two's-complement
// compare, done by inverting bit 3 of the most-significant nibble of both
// operands before it enters the slice (offset-binary transform).
module seq_nibble_compare
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_lt,
  output logic             out_eq,
  output logic             out_gt,
  output logic             busy
);

  localparam int NIB   = nib_count(WIDTH);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NIB - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDX_W-1:0] idx;
  cmp_res_t         cascade;
  cmp_res_t         slice_res;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic             accept;
  logic             scan_last;

  assign accept = (state == IDLE) && in_valid;

  // Nibble idx of each captured operand feeds the single slice.
  always_comb begin
    nib_a = a_q[{idx, 2'b00} +: 4];
    nib_b = b_q[{idx, 2'b00} +: 4];
`ifdef SEQ_NIBBLE_COMPARE_SIGNED_CMP_EN
    // Flipping the sign bit of both operands maps two's-complement order
    // onto unsigned order; only the top nibble carries the sign.
    if (idx == TOP_IDX) begin
      nib_a[3] = ~nib_a[3];
      nib_b[3] = ~nib_b[3];
    end
`endif
  end

  cmp4_slice u_slice (
    .a   (nib_a),
    .b   (nib_b),
    .cin (cascade),
    .res (slice_res)
  );

  assign scan_last = (idx == '0) || ((EARLY_EXIT != 0) && (slice_res != CMP_EQ));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = SCAN;
      SCAN: if (scan_last) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand, index and cascade registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      idx     <= TOP_IDX;
      cascade <= CMP_EQ;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= in_a;
            b_q     <= in_b;
            idx     <= TOP_IDX;
            cascade <= CMP_EQ;
          end
        end
        SCAN: begin
          // Scanning MSB first, the first unequal nibble decides. Once the
          // cascade is decided it is frozen, otherwise a lower unequal nibble
          // would override it during a full (non early-exit) scan.
          if (cascade == CMP_EQ) begin
            cascade <= slice_res;
          end
          if (!scan_last) begin
            idx <= idx - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == SCAN) || (state == DONE);
    out_lt    = (state == DONE) && (cascade == CMP_LT);
    out_eq    = (state == DONE) && (cascade == CMP_EQ);
    out_gt    = (state == DONE) && (cascade == CMP_GT);
  end

endmodule

// File: tb/tb_seq_nibble_compare.sv
// Bench for seq_nibble_compare: two instances (EARLY_EXIT=1 and 0) share the
// input stimulus; each is checked cycle by cycle against a reference model
// built from plain integer comparison and nibble-difference position.
module tb_seq_nibble_compare;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             out_ready = 1'b0;

  logic ee_in_ready, ee_out_valid, ee_lt, ee_eq, ee_gt, ee_busy;
  logic fu_in_ready, fu_out_valid, fu_lt, fu_eq, fu_gt, fu_busy;

  seq_nibble_compare #(.WIDTH(WIDTH), .EARLY_EXIT(1)) dut_ee (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ee_in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(ee_out_valid), .out_ready(out_ready),
    .out_lt(ee_lt), .out_eq(ee_eq), .out_gt(ee_gt), .busy(ee_busy)
  );

  seq_nibble_compare #(.WIDTH(WIDTH), .EARLY_EXIT(0)) dut_fu (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(fu_in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(fu_out_valid), .out_ready(out_ready),
    .out_lt(fu_lt), .out_eq(fu_eq), .out_gt(fu_gt), .busy(fu_busy)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected {lt,eq,gt} per instance, popped at handoff.
  logic [2:0] exp_q_ee[$];
  logic [2:0] exp_q_fu[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model
  function automatic logic [2:0] ref_verdict(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef SEQ_NIBBLE_COMPARE_SIGNED_CMP_EN
    return {$signed(a) < $signed(b), a == b, $signed(a) > $signed(b)};
`else
    return {a < b, a == b, a > b};
`endif
  endfunction

  // Number of nibbles examined before the verdict is known.
  function automatic int ref_nibbles(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input bit early);
    if (!early) return NIB;
    for (int p = 0; p < NIB; p++) begin
      if (((a >> (4 * (NIB - 1 - p))) & 'hF) != ((b >> (4 * (NIB - 1 - p))) & 'hF)) return p + 1;
    end
    return NIB;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_ee_in_ready"}, ee_in_ready, 1);
    check({tag, "_ee_out_valid"}, ee_out_valid, 0);
    check({tag, "_ee_verdict"}, {ee_lt, ee_eq, ee_gt}, 0);
    check({tag, "_ee_busy"}, ee_busy, 0);
    check({tag, "_fu_in_ready"}, fu_in_ready, 1);
    check({tag, "_fu_out_valid"}, fu_out_valid, 0);
    check({tag, "_fu_verdict"}, {fu_lt, fu_eq, fu_gt}, 0);
    check({tag, "_fu_busy"}, fu_busy, 0);
  endtask

  // One cycle of expectations for one instance. phase: 0 busy, 1 just handed
  // off (expect IDLE now), 2 finished.
  task automatic step_dut(input string nm, input int c, input int m, input logic [2:0] exp_v,
                          input logic rdy, input logic ov, input logic [2:0] verdict,
                          input logic bz, input logic ordy, inout int phase, output bit handoff);
    handoff = 1'b0;
    if (phase == 0) begin
      check({nm, "_in_ready_busy"}, rdy, 0);
      check({nm, "_busy"}, bz, 1);
      if (c >= m + 1) begin
        check({nm, "_out_valid"}, ov, 1);
        check({nm, "_verdict"}, verdict, exp_v);
        if (ordy) begin
          phase   = 1;
          handoff = 1'b1;
        end
      end else begin
        check({nm, "_out_valid_early"}, ov, 0);
        check({nm, "_verdict_zero"}, verdict, 0);
      end
    end else if (phase == 1) begin
      check({nm, "_idle_in_ready"}, rdy, 1);
      check({nm, "_idle_out_valid"}, ov, 0);
      check({nm, "_idle_busy"}, bz, 0);
      check({nm, "_idle_verdict"}, verdict, 0);
      phase = 2;
    end
  endtask

  // Driver: offer one pair at the current negedge, then track both instances
  // until each has handed off and returned to IDLE. out_ready is low until
  // cycle hold_until. glitch pulses a different pair during cycles 1-2.
  task automatic run_txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int hold_until, input bit glitch);
    int m_ee, m_fu;
    int ph_ee, ph_fu;
    bit h;
    m_ee  = ref_nibbles(a, b, 1'b1);
    m_fu  = ref_nibbles(a, b, 1'b0);
    ph_ee = 0;
    ph_fu = 0;
    exp_q_ee.push_back(ref_verdict(a, b));
    exp_q_fu.push_back(ref_verdict(a, b));
    check("accept_ee_in_ready", ee_in_ready, 1);
    check("accept_fu_in_ready", fu_in_ready, 1);
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      in_valid = glitch && (c <= 2);
      if (glitch) begin
        in_a = a ^ 16'h5a5a;
        in_b = b ^ 16'h0ff0;
      end
      out_ready = (c >= hold_until);
      step_dut("ee", c, m_ee, (exp_q_ee.size() > 0) ? exp_q_ee[0] : 3'b000,
               ee_in_ready, ee_out_valid, {ee_lt, ee_eq, ee_gt}, ee_busy, out_ready, ph_ee, h);
      if (h) void'(exp_q_ee.pop_front());
      step_dut("fu", c, m_fu, (exp_q_fu.size() > 0) ? exp_q_fu[0] : 3'b000,
               fu_in_ready, fu_out_valid, {fu_lt, fu_eq, fu_gt}, fu_busy, out_ready, ph_fu, h);
      if (h) void'(exp_q_fu.pop_front());
      if (ph_ee == 2 && ph_fu == 2) break;
    end
    if (!(ph_ee == 2 && ph_fu == 2)) check("txn_timeout", 0, 1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  // Driver: start a long compare and reset it mid-scan.
  task automatic run_reset_mid();
    in_a      = 16'hFFFF;
    in_b      = 16'h0000;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_mid_c1_fu_out_valid", fu_out_valid, 0);
    @(negedge clk);
    check("rst_mid_c2_fu_out_valid", fu_out_valid, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("rst_mid");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_mid_no_verdict_fu", fu_out_valid, 0);
      check("rst_mid_no_verdict_ee", ee_out_valid, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] a, b;
    int sel;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Equal operands: verdict at cycle 5, ready again by cycle 7.
    run_txn(16'hA5A5, 16'hA5A5, 0, 1'b0);
    @(negedge clk);
    check("a5a5_c7_ee_in_ready", ee_in_ready, 1);
    check("a5a5_c7_fu_in_ready", fu_in_ready, 1);

    // Top-nibble difference: early exit at cycle 2, full scan at cycle 5.
    run_txn(16'h1234, 16'h9234, 0, 1'b0);
    // Verdict held for 6 cycles of back-pressure.
    run_txn(16'h00F1, 16'h00F0, 11, 1'b0);
    // Abort by reset, then a clean compare.
    run_reset_mid();
    run_txn(16'h0000, 16'h0000, 0, 1'b0);
    // Sign-sensitive pair.
    run_txn(16'h8000, 16'h0001, 0, 1'b0);
    // New operands offered during SCAN must be ignored.
    run_txn(16'h1234, 16'h5678, 0, 1'b1);
    // Upper nibble decides even though a lower nibble disagrees the other way.
    run_txn(16'h0010, 16'h0001, 2, 1'b0);

    for (int n = 0; n < 40; n++) begin
      a   = WIDTH'($urandom);
      sel = $urandom_range(0, 2);
      if (sel == 0) b = a;
      else if (sel == 1) b = a ^ (WIDTH'($urandom_range(1, 15)) << (4 * $urandom_range(0, NIB - 1)));
      else b = WIDTH'($urandom);
      run_txn(a, b, $urandom_range(0, 8), 1'($urandom_range(0, 1)));
    end

    check("scoreboard_drained", exp_q_ee.size() + exp_q_fu.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
